brianhg_capture_wmem: RTL and testbench
=======================================

# BrianHG_capture_wmem

Raster capture writer for the DDR3 graphics path: accepts a pixel stream in the CMD_CLK domain, packs pixels into full-width write words with per-byte masks, and issues DDR3 write requests into a bitmap at a given base address, bitmap width, pixel depth and X/Y destination offset. It is the write-side counterpart of the display raster reader. Filled bitmaps are later read back for display. A small word FIFO absorbs write-port busy stalls.

## Interface
- PORT_ADDR_SIZE, 24, byte address width of the DDR3 write port.
- PORT_W_DATA_WIDTH, 128, write word width in bits; a power of 2, minimum 32.
- FIFO_DEPTH, 4, number of queued write words; a power of 2, minimum 2.

- CMD_CLK  in  1  clock.
- reset  in  1  synchronous, active-high; clock CMD_CLK.
- CAP_pixel_bytes  in  3  4=32-bit, 2=16-bit, any other value = 8-bit pixels.
- CAP_mem_addr  in  32  bitmap base byte address.
- CAP_bitmap_width  in  16  bitmap width in pixels.
- CAP_xsize, CAP_ysize  in  14 each  captured pixels per line / lines per frame.
- CAP_xpos, CAP_ypos  in  14 each  destination pixel offset within the bitmap.
- pix_sof  in  1  start-of-frame pulse.
- pix_sol  in  1  start-of-line pulse.
- pix_valid  in  1  pixel present on pix_data.
- pix_data  in  32  pixel, LSB-aligned; unused upper bytes are ignored.
- write_busy_in  in  1  DDR3 write port cannot accept this cycle.
- write_req_out  out  1  write word valid.
- write_adr_out  out  PORT_ADDR_SIZE  word-aligned byte address.
- write_data_out  out  PORT_W_DATA_WIDTH  write data.
- write_mask_out  out  PORT_W_DATA_WIDTH/8  byte enables; bit i = byte lane i.
- overflow_out  out  1  sticky: a word was dropped because the FIFO was full.
- busy_out  out  1  partial word pending or FIFO not empty.

## Operation
- WB = PORT_W_DATA_WIDTH/8. shift = 2, 1 or 0 for 4-, 2- or 1-byte pixels.
- All address math is done modulo 2^PORT_ADDR_SIZE. Low `shift` bits of CAP_mem_addr are forced to 0.
- Offset register: ((CAP_bitmap_width*CAP_ypos + CAP_xpos) << shift) is registered every cycle. Config inputs must be stable for at least 2 cycles before pix_sof.
- pix_sof:
  - Flush any partial word.
  - line_addr <= CAP_mem_addr + offset.
  - line_cnt <= 0, line_active <= 0.
  - overflow_out clears.
- pix_sol:
  - Flush any partial word.
  - If line_cnt < CAP_ysize: byte_ptr <= line_addr, pix_cnt <= 0, line_active <= 1; then line_addr += CAP_bitmap_width << shift and line_cnt += 1.
  - Otherwise line_active <= 0, and all pixels are dropped until the next pix_sof.
- pix_sof takes priority over pix_sol. pix_valid is ignored on any cycle where pix_sof or pix_sol is high.
- Packing, on pix_valid with line_active and pix_cnt < CAP_xsize:
  - lane = byte_ptr mod WB.
  - Bytes 0..(2^shift)-1 of pix_data are written to lanes lane.., and those mask bits are set.
  - The word address is latched from byte_ptr with its low log2(WB) bits cleared.
  - byte_ptr += 2^shift, pix_cnt += 1.
- A word is pushed to the FIFO when its last lane fills, or when pix_cnt reaches CAP_xsize (automatic end-of-line flush).
  - After a push, the packing mask and data clear.
  - Pixels arriving after CAP_xsize are dropped.
- Flushing an empty mask pushes nothing.
- FIFO push when full:
  - If a pop occurs the same cycle, the push succeeds.
  - Otherwise the word is dropped and overflow_out is set.
- Output side: write_req_out = FIFO not empty. write_adr/data/mask_out show the FIFO head.
- A word is accepted on any cycle where write_req_out=1 and write_busy_in=0; the head pops on that edge.
- busy_out = (pack mask != 0) or FIFO not empty.
- Reset values (reset applies on the next edge, including mid-line or mid-write):
  - All outputs are 0. FIFO empty, pack mask 0, line_active 0, line_cnt 0.
  - The partial word and queued words are discarded.

## Timing
- Pixel that completes a word at edge N: write_req_out is high after edge N, with that word at the head if the FIFO was empty.
- Flush on pix_sol/pix_sof/xsize at edge N: the word is visible after edge N.
- Accept at edge N: the next head (or write_req_out=0) is visible after edge N.
- Sustained throughput is 1 word per cycle with write_busy_in=0.
- The offset pipeline is 1 cycle; line_addr is valid from the cycle after pix_sof.

## Test plan
- Aligned 32-bit line:
  - Setup: WB=16, CAP_pixel_bytes=4, CAP_mem_addr=0x1000, width=640, xpos=ypos=0, xsize=8.
  - Stimulus: sof, sol, then 8 pixels.
  - Required: words at 0x1000 and 0x1010, mask 0xFFFF, data in lane order; busy_out returns to 0.
- Line stride: a second sol with the same config gives its first word at 0x1A00; with ysize=1, the second sol produces no writes.
- Unaligned 16-bit:
  - Setup: CAP_pixel_bytes=2, xpos=3, xsize=5, mem_addr=0x1000.
  - Required: one word at 0x1000 with mask 0xFFC0, pushed on the 5th pixel.
  - With xsize=2: auto-flush gives mask 0x03C0.
- Backpressure:
  - Stimulus: hold write_busy_in=1 while 5 full words are produced (FIFO_DEPTH=4).
  - Required: the 5th word is dropped, overflow_out=1, and 4 words drain in order after busy drops.
  - The next pix_sof clears overflow_out.
- Simultaneous push/pop while full: push succeeds with no overflow. pix_valid on a pix_sol cycle is ignored.
- Reset mid-line: assert reset with 2 pixels packed and 3 words queued. Required: all outputs 0 next cycle; no write issued until a new sof/sol.

Source files
------------

// File: rtl/brianhg_capture_wmem_if.sv
// DDR3 write-port bundle between the capture writer (master) and the memory port (slave).
interface brianhg_capture_wmem_if #(
  parameter int PORT_ADDR_SIZE    = 24,
  parameter int PORT_W_DATA_WIDTH = 128
);
  logic                             write_req_out;
  logic [PORT_ADDR_SIZE-1:0]        write_adr_out;
  logic [PORT_W_DATA_WIDTH-1:0]     write_data_out;
  logic [PORT_W_DATA_WIDTH/8-1:0]   write_mask_out;
  logic                             write_busy_in;

  modport master (
    output write_req_out, write_adr_out, write_data_out, write_mask_out,
    input  write_busy_in
  );

  modport slave (
    input  write_req_out, write_adr_out, write_data_out, write_mask_out,
    output write_busy_in
  );
endinterface

// File: rtl/brianhg_capture_wmem.sv
// Raster capture writer: packs a pixel stream into masked DDR3 write words
// addressed into a bitmap, with a small word FIFO to ride out port stalls.
module brianhg_capture_wmem #(
  parameter int PORT_ADDR_SIZE    = 24,
  parameter int PORT_W_DATA_WIDTH = 128,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                   CMD_CLK,
  input  logic                   reset,
  input  logic [2:0]             CAP_pixel_bytes,
  input  logic [31:0]            CAP_mem_addr,
  input  logic [15:0]            CAP_bitmap_width,
  input  logic [13:0]            CAP_xsize,
  input  logic [13:0]            CAP_ysize,
  input  logic [13:0]            CAP_xpos,
  input  logic [13:0]            CAP_ypos,
  input  logic                   pix_sof,
  input  logic                   pix_sol,
  input  logic                   pix_valid,
  input  logic [31:0]            pix_data,
  brianhg_capture_wmem_if.master wr,
  output logic                   overflow_out,
  output logic                   busy_out
);
  localparam int AW = PORT_ADDR_SIZE;
  localparam int DW = PORT_W_DATA_WIDTH;
  localparam int WB = DW / 8;
  localparam int LW = $clog2(WB);
  localparam int FW = $clog2(FIFO_DEPTH);

  logic [1:0]  w_shift;
  logic [2:0]  w_bytes;
  logic [3:0]  w_bmask;
  logic [31:0] w_keep;

  always_comb begin
    case (CAP_pixel_bytes)
      3'd4: begin w_shift = 2'd2; w_bytes = 3'd4; w_bmask = 4'hF; w_keep = 32'hFFFF_FFFF; end
      3'd2: begin w_shift = 2'd1; w_bytes = 3'd2; w_bmask = 4'h3; w_keep = 32'h0000_FFFF; end
      default: begin w_shift = 2'd0; w_bytes = 3'd1; w_bmask = 4'h1; w_keep = 32'h0000_00FF; end
    endcase
  end

  // All address arithmetic wraps naturally at the port address width.
  logic [AW-1:0] w_offset, w_base, w_stride;
  assign w_offset = (AW'(CAP_bitmap_width) * AW'(CAP_ypos) + AW'(CAP_xpos)) << w_shift;
  assign w_base   = AW'(CAP_mem_addr) & ~AW'(w_bytes - 3'd1);
  assign w_stride = AW'(CAP_bitmap_width) << w_shift;

  logic [AW-1:0] r_offset;
  logic [AW-1:0] r_line_addr, r_line_addr_next;
  logic [13:0]   r_line_cnt, r_line_cnt_next;
  logic          r_line_active, r_line_active_next;
  logic [AW-1:0] r_byte_ptr, r_byte_ptr_next;
  logic [13:0]   r_pix_cnt, r_pix_cnt_next;
  logic [DW-1:0] r_pack_data, r_pack_data_next;
  logic [WB-1:0] r_pack_mask, r_pack_mask_next;
  logic [AW-1:0] r_pack_addr, r_pack_addr_next;
  logic          r_overflow;

  logic [LW-1:0] w_lane;
  logic [DW-1:0] w_pix_ext, w_pix_lanes;
  logic [WB-1:0] w_mask_ext, w_mask_lanes;
  logic          w_lane_end;
  logic [AW-1:0] w_word_addr;

  assign w_lane = r_byte_ptr[LW-1:0];

  always_comb begin
    w_pix_ext        = '0;
    w_pix_ext[31:0]  = pix_data & w_keep;
    w_mask_ext       = '0;
    w_mask_ext[3:0]  = w_bmask;
  end

  assign w_pix_lanes  = w_pix_ext << {w_lane, 3'b000};
  assign w_mask_lanes = w_mask_ext << w_lane;
  assign w_lane_end   = ({1'b0, w_lane} + (LW+1)'(w_bytes)) == (LW+1)'(WB);
  assign w_word_addr  = {r_byte_ptr[AW-1:LW], {LW{1'b0}}};

  logic          w_push;
  logic [AW-1:0] w_push_addr;
  logic [DW-1:0] w_push_data;
  logic [WB-1:0] w_push_mask;

  always_comb begin
    r_line_addr_next   = r_line_addr;
    r_line_cnt_next    = r_line_cnt;
    r_line_active_next = r_line_active;
    r_byte_ptr_next    = r_byte_ptr;
    r_pix_cnt_next     = r_pix_cnt;
    r_pack_data_next   = r_pack_data;
    r_pack_mask_next   = r_pack_mask;
    r_pack_addr_next   = r_pack_addr;
    w_push             = 1'b0;
    w_push_addr        = r_pack_addr;
    w_push_data        = r_pack_data;
    w_push_mask        = r_pack_mask;
    if (pix_sof) begin
      w_push             = |r_pack_mask;
      r_pack_data_next   = '0;
      r_pack_mask_next   = '0;
      r_line_addr_next   = w_base + r_offset;
      r_line_cnt_next    = '0;
      r_line_active_next = 1'b0;
    end else if (pix_sol) begin
      w_push           = |r_pack_mask;
      r_pack_data_next = '0;
      r_pack_mask_next = '0;
      if (r_line_cnt < CAP_ysize) begin
        r_byte_ptr_next    = r_line_addr;
        r_pix_cnt_next     = '0;
        r_line_active_next = 1'b1;
        r_line_addr_next   = r_line_addr + w_stride;
        r_line_cnt_next    = r_line_cnt + 14'd1;
      end else begin
        r_line_active_next = 1'b0;
      end
    end else if (pix_valid && r_line_active && (r_pix_cnt < CAP_xsize)) begin
      r_byte_ptr_next  = r_byte_ptr + AW'(w_bytes);
      r_pix_cnt_next   = r_pix_cnt + 14'd1;
      r_pack_addr_next = w_word_addr;
      // Pixels never straddle a word: every pointer stays pixel-aligned.
      if (w_lane_end || (r_pix_cnt + 14'd1 == CAP_xsize)) begin
        w_push           = 1'b1;
        w_push_addr      = w_word_addr;
        w_push_data      = r_pack_data | w_pix_lanes;
        w_push_mask      = r_pack_mask | w_mask_lanes;
        r_pack_data_next = '0;
        r_pack_mask_next = '0;
      end else begin
        r_pack_data_next = r_pack_data | w_pix_lanes;
        r_pack_mask_next = r_pack_mask | w_mask_lanes;
      end
    end
  end

  logic [AW-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DW-1:0] r_fifo_data [FIFO_DEPTH];
  logic [WB-1:0] r_fifo_mask [FIFO_DEPTH];
  logic [FW-1:0] r_wr_ptr, r_rd_ptr;
  logic [FW:0]   r_count;
  logic          w_not_empty, w_full, w_pop, w_push_ok, w_drop;

  assign w_not_empty = r_count != '0;
  assign w_full      = r_count == (FW+1)'(FIFO_DEPTH);
  assign w_pop       = w_not_empty && !wr.write_busy_in;
  // A pop on the same edge frees the slot a full-FIFO push needs.
  assign w_push_ok   = w_push && (!w_full || w_pop);
  assign w_drop      = w_push && w_full && !w_pop;

  always_ff @(posedge CMD_CLK) begin
    if (w_push_ok) begin
      r_fifo_addr[r_wr_ptr] <= w_push_addr;
      r_fifo_data[r_wr_ptr] <= w_push_data;
      r_fifo_mask[r_wr_ptr] <= w_push_mask;
    end
  end

  always_ff @(posedge CMD_CLK) begin
    if (reset) begin
      r_offset      <= '0;
      r_line_addr   <= '0;
      r_line_cnt    <= '0;
      r_line_active <= 1'b0;
      r_byte_ptr    <= '0;
      r_pix_cnt     <= '0;
      r_pack_data   <= '0;
      r_pack_mask   <= '0;
      r_pack_addr   <= '0;
      r_overflow    <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
    end else begin
      r_offset      <= w_offset;
      r_line_addr   <= r_line_addr_next;
      r_line_cnt    <= r_line_cnt_next;
      r_line_active <= r_line_active_next;
      r_byte_ptr    <= r_byte_ptr_next;
      r_pix_cnt     <= r_pix_cnt_next;
      r_pack_data   <= r_pack_data_next;
      r_pack_mask   <= r_pack_mask_next;
      r_pack_addr   <= r_pack_addr_next;
      if (pix_sof) r_overflow <= 1'b0;
      if (w_drop)  r_overflow <= 1'b1;
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + FW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + FW'(1);
      r_count <= r_count + (FW+1)'(w_push_ok) - (FW+1)'(w_pop);
    end
  end

  assign wr.write_req_out  = w_not_empty;
  assign wr.write_adr_out  = w_not_empty ? r_fifo_addr[r_rd_ptr] : '0;
  assign wr.write_data_out = w_not_empty ? r_fifo_data[r_rd_ptr] : '0;
  assign wr.write_mask_out = w_not_empty ? r_fifo_mask[r_rd_ptr] : '0;
  assign overflow_out      = r_overflow;
  assign busy_out          = (|r_pack_mask) || w_not_empty;
endmodule

// File: tb/tb_brianhg_capture_wmem.sv
// Scoreboard bench: a byte-address pixel model predicts write words, a monitor checks them on accept.
module tb_brianhg_capture_wmem;
  localparam int AW = 24;
  localparam int DW = 128;
  localparam int WB = DW / 8;
  localparam int DEPTH = 4;
  localparam longint AMASK = 64'hFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [2:0]  cfg_pb;
  logic [31:0] cfg_addr;
  logic [15:0] cfg_width;
  logic [13:0] cfg_xsize, cfg_ysize, cfg_xpos, cfg_ypos;
  logic        pix_sof, pix_sol, pix_valid;
  logic [31:0] pix_data;
  logic        busy;
  logic        overflow_out, busy_out;

  brianhg_capture_wmem_if #(.PORT_ADDR_SIZE(AW), .PORT_W_DATA_WIDTH(DW)) wif ();
  assign wif.write_busy_in = busy;

  brianhg_capture_wmem #(.PORT_ADDR_SIZE(AW), .PORT_W_DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .CMD_CLK(clk), .reset(reset),
    .CAP_pixel_bytes(cfg_pb), .CAP_mem_addr(cfg_addr), .CAP_bitmap_width(cfg_width),
    .CAP_xsize(cfg_xsize), .CAP_ysize(cfg_ysize), .CAP_xpos(cfg_xpos), .CAP_ypos(cfg_ypos),
    .pix_sof(pix_sof), .pix_sol(pix_sol), .pix_valid(pix_valid), .pix_data(pix_data),
    .wr(wif), .overflow_out(overflow_out), .busy_out(busy_out)
  );

  typedef struct {
    logic [AW-1:0] adr;
    logic [DW-1:0] data;
    logic [WB-1:0] mask;
  } word_t;

  word_t  exp_q[$];
  int     checks = 0;
  int     errors = 0;

  // Reference model state: absolute byte addresses, one open word, FIFO occupancy.
  int     m_count;
  bit     m_ovf;
  bit     m_active;
  int     m_line, m_pix;
  longint m_frame_base, m_line_base;
  word_t  m_open;

  function automatic int bpp_of(logic [2:0] pb);
    return (pb == 3'd4) ? 4 : ((pb == 3'd2) ? 2 : 1);
  endfunction

  task automatic model_edge(input bit rst, input bit sof, input bit sol, input bit vld,
                            input logic [31:0] d, input bit bsy);
    word_t  w;
    bit     have;
    bit     pop;
    int     bpp;
    int     lane;
    longint a;
    have = 1'b0;
    if (rst) begin
      m_count = 0; m_ovf = 1'b0; m_active = 1'b0; m_line = 0; m_pix = 0;
      m_open = '{default: '0};
      exp_q.delete();
      return;
    end
    pop = (m_count > 0) && !bsy;
    bpp = bpp_of(cfg_pb);
    if (sof || sol) begin
      if (m_open.mask != '0) begin w = m_open; have = 1'b1; end
      m_open = '{default: '0};
    end
    if (sof) begin
      m_frame_base = ((longint'(cfg_addr) & ~longint'(bpp - 1)) +
                      (longint'(cfg_width) * longint'(cfg_ypos) + longint'(cfg_xpos)) * bpp) & AMASK;
      m_line = 0;
      m_active = 1'b0;
    end else if (sol) begin
      if (m_line < int'(cfg_ysize)) begin
        m_line_base = (m_frame_base + longint'(m_line) * longint'(cfg_width) * bpp) & AMASK;
        m_line++;
        m_pix = 0;
        m_active = 1'b1;
      end else begin
        m_active = 1'b0;
      end
    end else if (vld && m_active && m_pix < int'(cfg_xsize)) begin
      a = (m_line_base + longint'(m_pix) * bpp) & AMASK;
      lane = int'(a % WB);
      m_open.adr = AW'(a - lane);
      for (int b = 0; b < bpp; b++) begin
        m_open.data[8*(lane+b) +: 8] = d[8*b +: 8];
        m_open.mask[lane+b] = 1'b1;
      end
      m_pix++;
      if (lane + bpp == WB || m_pix == int'(cfg_xsize)) begin
        w = m_open; have = 1'b1;
        m_open = '{default: '0};
      end
    end
    if (sof) m_ovf = 1'b0;
    if (have) begin
      if (m_count < DEPTH || pop) begin
        exp_q.push_back(w);
        m_count++;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (pop) m_count--;
  endtask

  task automatic cyc(input bit sof, input bit sol, input bit vld, input logic [31:0] d,
                     input bit bsy, input bit rst = 1'b0);
    reset = rst; pix_sof = sof; pix_sol = sol; pix_valid = vld; pix_data = d; busy = bsy;
    model_edge(rst, sof, sol, vld, d, bsy);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_count != 0) && n < 200) begin
      cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || m_count != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
    end
    chk("idle_req", 128'(wif.write_req_out), 128'd0);
  endtask

  task automatic set_cfg(input logic [2:0] pb, input logic [31:0] addr, input logic [15:0] width,
                         input int xpos, input int ypos, input int xsize, input int ysize);
    cfg_pb = pb; cfg_addr = addr; cfg_width = width;
    cfg_xpos = 14'(xpos); cfg_ypos = 14'(ypos); cfg_xsize = 14'(xsize); cfg_ysize = 14'(ysize);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  // Monitor: a word is accepted on the next edge whenever req is high and busy is low.
  word_t mw;
  initial begin
    forever begin
      @(negedge clk);
      if (wif.write_req_out && !busy && !reset) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write actual adr=%06h mask=%04h required none",
                   wif.write_adr_out, wif.write_mask_out);
        end else begin
          mw = exp_q.pop_front();
          if (wif.write_adr_out !== mw.adr || wif.write_data_out !== mw.data ||
              wif.write_mask_out !== mw.mask) begin
            errors++;
            $display("FAIL write_word actual adr=%06h mask=%04h data=%032h required adr=%06h mask=%04h data=%032h",
                     wif.write_adr_out, wif.write_mask_out, wif.write_data_out, mw.adr, mw.mask, mw.data);
          end else begin
            $display("write adr=%06h mask=%04h data=%032h", mw.adr, mw.mask, mw.data);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; pix_sof = 1'b0; pix_sol = 1'b0; pix_valid = 1'b0; pix_data = '0; busy = 1'b0;
    cfg_pb = 3'd4; cfg_addr = 32'h1000; cfg_width = 16'd640;
    cfg_xpos = '0; cfg_ypos = '0; cfg_xsize = 14'd8; cfg_ysize = 14'd2;
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    chk("reset_req", 128'(wif.write_req_out), 128'd0);
    chk("reset_busy", 128'(busy_out), 128'd0);
    chk("reset_ovf", 128'(overflow_out), 128'd0);

    // Aligned 32-bit line, then line stride.
    set_cfg(3'd4, 32'h1000, 16'd640, 0, 0, 8, 2);
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    for (int p = 0; p < 8; p++) begin
      cyc(1'b0, 1'b0, 1'b1, $urandom, 1'b0);
      if (p == 3) begin
        chk("aligned_req", 128'(wif.write_req_out), 128'd1);
        chk("aligned_adr", 128'(wif.write_adr_out), 128'h1000);
        chk("aligned_mask", 128'(wif.write_mask_out), 128'hFFFF);
      end
    end
    drain();
    chk("aligned_busy_done", 128'(busy_out), 128'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    for (int p = 0; p < 4; p++) cyc(1'b0, 1'b0, 1'b1, $urandom, 1'b1);
    chk("stride_adr", 128'(wif.write_adr_out), 128'h1A00);
    drain();

    // ysize=1: the second line is dropped entirely.
    set_cfg(3'd4, 32'h1000, 16'd640, 0, 0, 8, 1);
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    for (int l = 0; l < 2; l++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
      for (int p = 0; p < 8; p++) cyc(1'b0, 1'b0, 1'b1, $urandom, 1'b0);
    end
    drain();
    chk("ysize_limit_busy", 128'(busy_out), 128'd0);

    // Unaligned 16-bit pixels starting at lane 6.
    set_cfg(3'd2, 32'h1000, 16'd640, 3, 0, 5, 1);
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    for (int p = 0; p < 4; p++) cyc(1'b0, 1'b0, 1'b1, $urandom, 1'b0);
    chk("unaligned_no_push", 128'(wif.write_req_out), 128'd0);
    cyc(1'b0, 1'b0, 1'b1, $urandom, 1'b0);
    chk("unaligned_req", 128'(wif.write_req_out), 128'd1);
    chk("unaligned_adr", 128'(wif.write_adr_out), 128'h1000);
    chk("unaligned_mask", 128'(wif.write_mask_out), 128'hFFC0);
    drain();
    set_cfg(3'd2, 32'h1000, 16'd640, 3, 0, 2, 1);
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    for (int p = 0; p < 2; p++) cyc(1'b0, 1'b0, 1'b1, $urandom, 1'b0);
    chk("autoflush_mask", 128'(wif.write_mask_out), 128'h03C0);
    drain();

    // Backpressure: five words into a four-deep FIFO.
    set_cfg(3'd4, 32'h2000, 16'd640, 0, 0, 20, 1);
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    for (int p = 0; p < 20; p++) cyc(1'b0, 1'b0, 1'b1, $urandom, 1'b1);
    chk("overflow_set", 128'(overflow_out), 128'd1);
    chk("overflow_req", 128'(wif.write_req_out), 128'd1);
    drain();
    chk("overflow_sticky", 128'(overflow_out), 128'd1);
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("overflow_cleared", 128'(overflow_out), 128'd0);

    // Push and pop on the same edge while full; valid on the sol cycle is ignored.
    set_cfg(3'd4, 32'h3000, 16'd640, 0, 0, 20, 1);
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
    for (int p = 0; p < 20; p++) cyc(1'b0, 1'b0, 1'b1, $urandom, (p != 19));
    chk("full_pushpop_no_ovf", 128'(overflow_out), 128'd0);
    drain();

    // Reset mid-line with three queued words and a partial word.
    set_cfg(3'd4, 32'h4000, 16'd640, 0, 0, 20, 1);
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    for (int p = 0; p < 14; p++) cyc(1'b0, 1'b0, 1'b1, $urandom, 1'b1);
    chk("pre_reset_busy", 128'(busy_out), 128'd1);
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    chk("midreset_req", 128'(wif.write_req_out), 128'd0);
    chk("midreset_adr", 128'(wif.write_adr_out), 128'd0);
    chk("midreset_data", 128'(wif.write_data_out), 128'd0);
    chk("midreset_mask", 128'(wif.write_mask_out), 128'd0);
    chk("midreset_busy", 128'(busy_out), 128'd0);
    chk("midreset_ovf", 128'(overflow_out), 128'd0);
    for (int p = 0; p < 6; p++) cyc(1'b0, 1'b0, 1'b1, $urandom, 1'b0);
    chk("post_reset_no_write", 128'(busy_out), 128'd0);

    // Randomized frames against the model.
    for (int f = 0; f < 8; f++) begin
      logic [2:0] pb;
      case ($urandom_range(0, 3))
        0: pb = 3'd4;
        1: pb = 3'd2;
        2: pb = 3'd1;
        default: pb = 3'd3;
      endcase
      set_cfg(pb, $urandom, 16'($urandom_range(16, 200)), $urandom_range(0, 7),
              $urandom_range(0, 5), $urandom_range(1, 24), $urandom_range(1, 3));
      cyc(1'b1, 1'b0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) == 0));
      for (int l = 0; l <= int'(cfg_ysize); l++) begin
        cyc(1'b0, 1'b1, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) == 0));
        for (int p = 0; p < int'(cfg_xsize) + 4; p++)
          cyc(1'b0, 1'b0, 1'($urandom_range(0, 9) < 7), $urandom, 1'($urandom_range(0, 3) == 0));
      end
    end
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    drain();
    chk("final_busy", 128'(busy_out), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
